// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, default timing/width and line levels.
// Used by both the transmitter and the receiver so their frame format cannot drift apart.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    START = 2'b01,
    DATA  = 2'b11,
    STOP  = 2'b10
  } uart_state_e;

  localparam int unsigned DEFAULT_CLOCKS_PER_PULSE = 16;
  localparam int unsigned DEFAULT_DATA_WIDTH       = 8;

  localparam logic START_BIT_LEVEL = 1'b0;
  localparam logic STOP_BIT_LEVEL  = 1'b1;
  localparam logic IDLE_LEVEL      = 1'b1;

endpackage : uart_pkg

// File: rtl/uart_tx_fifo.sv
// Small registered FIFO with wrapping read/write pointers and an occupancy count.
// No bypass: a pushed word becomes visible on rdata only after the push edge.
module uart_tx_fifo #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic                          push,
  input  logic                          pop,
  input  logic [DATA_WIDTH-1:0]         wdata,
  output logic [DATA_WIDTH-1:0]         rdata,
  output logic                          full,
  output logic                          empty,
  output logic [$clog2(FIFO_DEPTH):0]   count
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    unique case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is deliberately not reset; an entry is only read after a push has written it.
  always_ff @(posedge clk) begin
    if (rstn && push) mem_q[wr_ptr_q] <= wdata;
  end

  assign rdata = mem_q[rd_ptr_q];
  assign full  = (count_q == CNT_W'(FIFO_DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;

endmodule : uart_tx_fifo

// File: rtl/uart_tx.sv
// UART transmitter: buffers words from a valid/ready port and serialises them as
// start bit, DATA_WIDTH data bits LSB first, stop bit, with back-to-back frames when queued.
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned CLOCKS_PER_PULSE = DEFAULT_CLOCKS_PER_PULSE,
  parameter int unsigned DATA_WIDTH       = DEFAULT_DATA_WIDTH,
  parameter int unsigned FIFO_DEPTH       = 4
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  data_valid,
  output logic                  data_ready,
  output logic                  tx,
  output logic                  busy
);

  localparam int unsigned CLK_W = $clog2(CLOCKS_PER_PULSE);
  localparam int unsigned BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

  localparam logic [CLK_W-1:0] CLK_LAST = CLK_W'(CLOCKS_PER_PULSE - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_WIDTH - 1);

  uart_state_e           state_q, state_d;
  logic [CLK_W-1:0]      c_clocks_q, c_clocks_d;
  logic [BIT_W-1:0]      c_bits_q, c_bits_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  tx_q, tx_d;
  logic                  busy_q, busy_d;

  logic                  push, pop;
  logic                  fifo_full, fifo_empty;
  logic [DATA_WIDTH-1:0] fifo_rdata;
  logic [CNT_W-1:0]      fifo_count, next_count;
  logic                  bit_end;

  assign data_ready = !fifo_full;
  assign push       = data_valid && data_ready;
  assign bit_end    = (c_clocks_q == CLK_LAST);
  assign next_count = fifo_count + CNT_W'(push) - CNT_W'(pop);

  uart_tx_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (push),
    .pop   (pop),
    .wdata (data_in),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_comb begin
    state_d    = state_q;
    c_clocks_d = c_clocks_q;
    c_bits_d   = c_bits_q;
    shift_d    = shift_q;
    tx_d       = tx_q;
    pop        = 1'b0;

    unique case (state_q)
      IDLE: begin
        tx_d = IDLE_LEVEL;
        if (!fifo_empty) begin
          pop        = 1'b1;
          shift_d    = fifo_rdata;
          c_clocks_d = '0;
          tx_d       = START_BIT_LEVEL;
          state_d    = START;
        end
      end
      START: begin
        if (bit_end) begin
          c_clocks_d = '0;
          tx_d       = shift_q[0];
          state_d    = DATA;
        end else begin
          c_clocks_d = c_clocks_q + CLK_W'(1);
        end
      end
      DATA: begin
        if (bit_end) begin
          c_clocks_d = '0;
          shift_d    = shift_q >> 1;
          if (c_bits_q == BIT_LAST) begin
            c_bits_d = '0;
            tx_d     = STOP_BIT_LEVEL;
            state_d  = STOP;
          end else begin
            c_bits_d = c_bits_q + BIT_W'(1);
            tx_d     = shift_d[0];
          end
        end else begin
          c_clocks_d = c_clocks_q + CLK_W'(1);
        end
      end
      STOP: begin
        if (bit_end) begin
          c_clocks_d = '0;
          // Chaining straight into the next start bit keeps queued frames gap-free.
          if (!fifo_empty) begin
            pop     = 1'b1;
            shift_d = fifo_rdata;
            tx_d    = START_BIT_LEVEL;
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end else begin
          c_clocks_d = c_clocks_q + CLK_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = IDLE_LEVEL;
      end
    endcase

    busy_d = (state_d != IDLE) || (next_count != '0);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q    <= IDLE;
      c_clocks_q <= '0;
      c_bits_q   <= '0;
      shift_q    <= '0;
      tx_q       <= IDLE_LEVEL;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      c_clocks_q <= c_clocks_d;
      c_bits_q   <= c_bits_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
    end
  end

  assign tx   = tx_q;
  assign busy = busy_q;

endmodule : uart_tx

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: a behavioural line receiver pops a scoreboard of
// accepted words, plus cycle-exact waveform, handshake, reset and stall checks.
module tb_uart_tx;

  localparam int CPP_A = 16;
  localparam int CPP_B = 2;
  localparam int DW    = 8;
  localparam int DEPTH = 4;

  logic       clk  = 1'b0;
  logic       rstn = 1'b0;
  logic [7:0] din_a = '0, din_b = '0;
  logic       valid_a = 1'b0, valid_b = 1'b0;
  logic       ready_a, ready_b, tx_a, tx_b, busy_a, busy_b;

  int         n_checks = 0;
  int         n_errors = 0;
  int         cyc = 0;
  logic [7:0] sb_a[$];
  logic [7:0] sb_b[$];
  int         starts_a[$];
  int         frames_a = 0;
  int         frames_b = 0;
  bit         reset_seen_a = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_tx #(.CLOCKS_PER_PULSE(CPP_A), .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) u_dut_a (
    .clk(clk), .rstn(rstn), .data_in(din_a), .data_valid(valid_a),
    .data_ready(ready_a), .tx(tx_a), .busy(busy_a)
  );

  uart_tx #(.CLOCKS_PER_PULSE(CPP_B), .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) u_dut_b (
    .clk(clk), .rstn(rstn), .data_in(din_b), .data_valid(valid_b),
    .data_ready(ready_b), .tx(tx_b), .busy(busy_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Scoreboard tap: every handshake pushes the word the receiver must later see.
  always @(posedge clk) begin
    if (!rstn) reset_seen_a = 1'b1;
    else begin
      if (valid_a && ready_a) sb_a.push_back(din_a);
      if (valid_b && ready_b) sb_b.push_back(din_b);
    end
  end

  function automatic logic get_tx(input bit sel);
    return sel ? tx_b : tx_a;
  endfunction

  // Line receiver: finds the start bit, samples each bit at its centre, compares to scoreboard.
  task automatic rx_monitor(input bit sel, input int cpp);
    logic [7:0] w;
    logic       start_ok, stop_ok;
    bit         aborted;
    forever begin
      @(negedge clk);
      if (rstn && get_tx(sel) === 1'b0) begin
        if (!sel) begin
          reset_seen_a = 1'b0;
          starts_a.push_back(cyc);
        end
        repeat (cpp / 2) @(negedge clk);
        start_ok = (get_tx(sel) === 1'b0);
        for (int i = 0; i < DW; i++) begin
          repeat (cpp) @(negedge clk);
          w[i] = get_tx(sel);
        end
        repeat (cpp) @(negedge clk);
        stop_ok = (get_tx(sel) === 1'b1);
        aborted = !sel && reset_seen_a;
        if (!aborted) begin
          check(sel ? "rx_b_start" : "rx_a_start", 32'(start_ok), 1);
          check(sel ? "rx_b_stop" : "rx_a_stop", 32'(stop_ok), 1);
          if (sel) begin
            if (sb_b.size() == 0) check("rx_b_unexpected_frame", 1, 0);
            else check("rx_b_data", 32'(w), 32'(sb_b.pop_front()));
            frames_b++;
          end else begin
            if (sb_a.size() == 0) check("rx_a_unexpected_frame", 1, 0);
            else check("rx_a_data", 32'(w), 32'(sb_a.pop_front()));
            frames_a++;
          end
        end
      end
    end
  endtask

  initial rx_monitor(1'b0, CPP_A);
  initial rx_monitor(1'b1, CPP_B);

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle_a(input int max_cycles);
    int n = 0;
    while (busy_a && n < max_cycles) begin
      step();
      n++;
    end
    check("idle_timeout_a", 32'(busy_a), 0);
  endtask

  initial begin
    logic [7:0] pat;
    logic       exp_tx;
    logic [7:0] words[6];
    int         idx, e;
    bit         acc, quiet_bad;

    // Reset state
    rstn = 1'b0;
    repeat (3) step();
    @(negedge clk);
    check("rst_tx_a", 32'(tx_a), 1);
    check("rst_busy_a", 32'(busy_a), 0);
    check("rst_ready_a", 32'(ready_a), 1);
    check("rst_tx_b", 32'(tx_b), 1);
    check("rst_busy_b", 32'(busy_b), 0);
    check("rst_ready_b", 32'(ready_b), 1);
    rstn = 1'b1;
    step();

    // Single word 0xA5: cycle-exact waveform and busy window
    pat = 8'hA5;
    din_a = pat; valid_a = 1'b1;
    step();
    valid_a = 1'b0; din_a = 8'h00;
    for (int k = 0; k <= 175; k++) begin
      @(negedge clk);
      if (k == 0)        exp_tx = 1'b1;
      else if (k <= 16)  exp_tx = 1'b0;
      else if (k <= 144) exp_tx = pat[(k - 17) / 16];
      else               exp_tx = 1'b1;
      check("t1_tx", 32'(tx_a), 32'(exp_tx));
      check("t1_busy", 32'(busy_a), 32'(k <= 160));
      step();
    end

    // Loopback burst: three words on consecutive edges, frames must abut
    starts_a.delete();
    foreach (pat[i]) begin end
    din_a = 8'h00; valid_a = 1'b1; step();
    din_a = 8'hFF; step();
    din_a = 8'h3C; step();
    valid_a = 1'b0;
    wait_idle_a(700);
    repeat (5) step();
    check("t2_frames", 32'(starts_a.size()), 3);
    if (starts_a.size() == 3) begin
      check("t2_gap01", 32'(starts_a[1] - starts_a[0]), 160);
      check("t2_gap12", 32'(starts_a[2] - starts_a[1]), 160);
    end
    check("t2_sb_empty", 32'(sb_a.size()), 0);

    // FIFO full: data_valid held high over six distinct words
    words = '{8'h11, 8'h22, 8'h44, 8'h88, 8'hC3, 8'h7E};
    idx = 0; e = 0;
    din_a = words[0]; valid_a = 1'b1;
    while (idx < 6 && e < 400) begin
      check("t3_ready", 32'(ready_a), 32'((e <= 4) || (e >= 162)));
      acc = ready_a;
      step();
      if (acc) begin
        idx++;
        if (idx < 6) din_a = words[idx];
      end
      e++;
    end
    valid_a = 1'b0;
    check("t3_accepted", 32'(idx), 6);
    check("t3_last_edge", 32'(e), 163);
    wait_idle_a(1200);
    repeat (5) step();
    check("t3_sb_empty", 32'(sb_a.size()), 0);

    // Reset during data bit 3 of the first of three queued frames
    din_a = 8'h12; valid_a = 1'b1; step();
    din_a = 8'h34; step();
    din_a = 8'h56; step();
    valid_a = 1'b0;
    repeat (68) step();
    rstn = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("t4_rst1_tx", 32'(tx_a), 1);
    check("t4_rst1_busy", 32'(busy_a), 0);
    check("t4_rst1_ready", 32'(ready_a), 1);
    @(posedge clk);
    @(negedge clk);
    check("t4_rst2_tx", 32'(tx_a), 1);
    check("t4_rst2_busy", 32'(busy_a), 0);
    rstn = 1'b1;
    sb_a.delete();
    step();
    quiet_bad = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (tx_a !== 1'b1 || busy_a !== 1'b0) quiet_bad = 1'b1;
      step();
    end
    check("t4_no_residual_tx", 32'(quiet_bad), 0);
    din_a = 8'h5A; valid_a = 1'b1; step();
    valid_a = 1'b0;
    wait_idle_a(300);
    repeat (5) step();
    check("t4_sb_empty", 32'(sb_a.size()), 0);

    // Minimum bit time on the CPP=2 instance: 0x81
    pat = 8'h81;
    din_b = pat; valid_b = 1'b1;
    step();
    valid_b = 1'b0;
    for (int k = 0; k <= 24; k++) begin
      @(negedge clk);
      if (k == 0)       exp_tx = 1'b1;
      else if (k <= 2)  exp_tx = 1'b0;
      else if (k <= 18) exp_tx = pat[(k - 3) / 2];
      else              exp_tx = 1'b1;
      check("t5_tx", 32'(tx_b), 32'(exp_tx));
      check("t5_busy", 32'(busy_b), 32'(k <= 20));
      step();
    end
    check("t5_sb_empty", 32'(sb_b.size()), 0);

    // Stalled handshake: data_in toggles with data_valid low
    for (int k = 0; k < 100; k++) begin
      din_a = 8'($urandom);
      din_b = 8'($urandom);
      @(negedge clk);
      check("t6_tx", 32'(tx_a), 1);
      check("t6_busy", 32'(busy_a), 0);
      step();
    end
    check("t6_sb_a_empty", 32'(sb_a.size()), 0);
    check("frames_a_total", 32'(frames_a), 11);
    check("frames_b_total", 32'(frames_b), 1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule : tb_uart_tx

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- Serial UART transmitter, the companion to the team's UART receiver. Same frame format and the same CLOCKS_PER_PULSE bit timing.
- Accepts parallel words over a valid/ready handshake and buffers them in a small FIFO.
- Serialises each word onto `tx` as: 1 start bit (low), DATA_WIDTH data bits LSB first, 1 stop bit (high).
- Sits between the bus-side logic and the UART pin. Its output loops directly into the receiver in test.

Parameters:
- CLOCKS_PER_PULSE, 16, clock cycles per serial bit; must be >= 2; must match the receiver.
- DATA_WIDTH, 8, bits per frame payload.
- FIFO_DEPTH, 4, transmit buffer entries; power of two, >= 2.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rstn  in  1  reset, synchronous, active-low.
- data_in  in  DATA_WIDTH  word to transmit.
- data_valid  in  1  data_in valid; push occurs on an edge where data_valid && data_ready.
- data_ready  out  1  = !fifo_full; combinational from FIFO count.
- tx  out  1  serial line, registered, idles high.
- busy  out  1  high while a frame is in progress or the FIFO is non-empty; registered.

Behaviour:
- Reset (rstn low at an edge):
  - tx=1, busy=0, FIFO count=0 (so data_ready=1), state=IDLE, counters cleared.
  - A partial frame is abandoned and queued words are discarded.
  - A push presented during reset is ignored.
- FIFO:
  - Registered, with separate read and write pointers of log2(FIFO_DEPTH) bits that wrap naturally, plus a count of log2(FIFO_DEPTH)+1 bits.
  - No bypass: a word pushed at edge k is visible to the FSM only after edge k.
  - Simultaneous push and pop: count unchanged, both pointers advance.
  - Push when full is impossible (data_ready=0).
  - Pop when empty never occurs.
- FSM states IDLE, START, DATA, STOP; counters c_clocks (0..CLOCKS_PER_PULSE-1) and c_bits (0..DATA_WIDTH-1).
  - IDLE:
    - tx=1.
    - If FIFO non-empty: pop the head into shift register, c_clocks=0, state=START, tx driven 0 at the same edge.
  - START:
    - tx=0 for CLOCKS_PER_PULSE cycles.
    - At c_clocks==CLOCKS_PER_PULSE-1: c_clocks=0, tx=shift[0], state=DATA.
  - DATA:
    - Hold each bit CLOCKS_PER_PULSE cycles.
    - At the end of each bit: shift right.
    - If c_bits==DATA_WIDTH-1: c_bits=0, tx=1, state=STOP; otherwise c_bits+1, tx=next bit.
  - STOP:
    - tx=1 for CLOCKS_PER_PULSE cycles.
    - At the last cycle, if FIFO non-empty: pop, tx=0, state=START. This gives back-to-back frames with zero idle gap.
    - Otherwise state=IDLE.
- Latency:
  - Push at edge k into an empty FIFO while IDLE → pop at edge k+1 → tx low from edge k+1.
  - Frame length is exactly (DATA_WIDTH+2)*CLOCKS_PER_PULSE cycles.
- busy: next-state registered as (next_state!=IDLE) || (next_count!=0).
- data_in need not be held after the handshake edge.

Decomposition:
- Shared package / include uart_pkg holds:
  - TX and RX state encodings (IDLE=2'b00, START=2'b01, DATA=2'b11, STOP=2'b10).
  - Default CLOCKS_PER_PULSE and DATA_WIDTH.
  - Frame constants: start bit level 0, stop/idle level 1.
- One sub-module: uart_tx_fifo (parameters DATA_WIDTH, FIFO_DEPTH; ports push, pop, wdata, rdata, full, empty).
  - Reusable later as a receive buffer.

Test Plan:
- Single word, CPP=16: push 0xA5 at edge 0.
  - tx low for cycles 1–16.
  - Then bits 1,0,1,0,0,1,0,1 for 16 cycles each.
  - Stop high for 16 cycles.
  - busy falls after cycle 160; tx stays high afterwards.
- Loopback into uart_rx (same parameters): push 0x00, 0xFF, 0x3C on consecutive cycles.
  - Receiver data_out sequence is 0x00, 0xFF, 0x3C.
  - Frame 2 start bit begins exactly 160 cycles after frame 1 start bit; no idle gap.
- FIFO full, FIFO_DEPTH=4: hold data_valid high with 6 distinct words.
  - Exactly 5 accepted on consecutive edges (one popped at edge 1).
  - data_ready=0 until the pop at the end of frame 1.
  - 6th accepted on that edge.
  - All 6 transmitted in order.
- Reset mid-frame: queue 3 words, drive rstn low for 2 cycles during data bit 3 of frame 1.
  - tx=1 and busy=0 from the first reset edge; data_ready=1.
  - Remaining queued words are never transmitted.
  - A new push after reset transmits normally.
- Minimum timing, CPP=2, DATA_WIDTH=8: push 0x81.
  - Frame is 20 cycles: 0, then 1,0,0,0,0,0,0,1, then 1, each for 2 cycles.
  - Receiver recovers 0x81.
- Stalled handshake: data_valid=0 with data_in toggling for 100 cycles.
  - tx stays 1, busy stays 0, no push occurs.
